voice_alloc_sched: RTL and testbench
====================================

Name: voice_alloc_sched

Overview:
- Polyphonic voice allocator and event scheduler.
- Takes decoded MIDI note-on/note-off events and assigns each to a voice slot (reuse of an already-held key, else first free slot, else round-robin steal).
- Drives note_on / cur_key_adr / cur_key_val / cur_vel_on / keys_on into the OSC_CLK-domain note/key/velocity frame synchroniser.
- Holds each result stable for a configurable number of voice frames, so every event is sampled at a frame boundary.

Parameters:
VOICES, 8, number of voice slots
V_WIDTH, 3, voice index width, clog2(VOICES)
HOLD_FRAMES, 2, frame_tick pulses outputs are held after each commit (min 1)

Ports:
OSC_CLK  in  1  system clock
n_reset  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse per voice frame (synchronous to OSC_CLK)
ev_valid  in  1  event request
ev_ready  out  1  event accepted when ev_valid && ev_ready
ev_note_on  in  1  1 = note-on, 0 = note-off
ev_key  in  8  key number
ev_vel  in  8  velocity
all_notes_off  in  1  one-cycle pulse; release every voice
note_on  out  1  level: 1 while a note-on commit is held
cur_key_adr  out  V_WIDTH  voice slot of last commit
cur_key_val  out  8  key of last commit
cur_vel_on  out  8  velocity of last note-on commit
keys_on  out  VOICES  per-voice gate bitmap
busy  out  1  state != IDLE

Behaviour:
- Reset (async, n_reset low): state IDLE, every output 0, internal key table 0, steal_ptr 0, frame counter 0. Reset mid-operation aborts the event with no partial update.
- ev_ready = (state==IDLE) && !all_notes_off. Combinational.
- A note-on with ev_vel==0 is treated as a note-off.
- FSM states: IDLE, SCAN, COMMIT, HOLD.
- IDLE:
  - all_notes_off has priority: keys_on<=0, note_on<=0, go to HOLD.
  - Else, on handshake: latch key, vel and type; clear match/free flags; scan index=0; go to SCAN.
  - all_notes_off outside IDLE is ignored; the source must retry when busy=0.
- SCAN: one voice per cycle, index 0..VOICES-1, exactly VOICES cycles.
  - match: first i with keys_on[i] && key_tab[i]==key (full 8-bit compare).
  - free: first i with !keys_on[i].
  - After index VOICES-1, go to COMMIT.
- COMMIT (one cycle; outputs registered at this edge):
  - Note-on, slot = match, else free, else steal_ptr. steal_ptr increments mod VOICES only when stealing. Updates: key_tab[slot]<=key, keys_on[slot]<=1, cur_key_adr<=slot, cur_key_val<=key, cur_vel_on<=vel, note_on<=1. Go to HOLD.
  - Note-off with match: keys_on[match]<=0, cur_key_adr<=match, cur_key_val<=key, note_on<=0, cur_vel_on unchanged. Go to HOLD.
  - Note-off without match: no output change; go directly to IDLE.
- HOLD:
  - Count frame_tick pulses; a tick coincident with COMMIT is not counted.
  - After HOLD_FRAMES ticks, go to IDLE. Outputs stay unchanged; note_on remains at its committed level until the next commit.
- Latency: handshake at cycle T; outputs valid from cycle T+VOICES+2. ev_ready is next high the cycle after the HOLD_FRAMES-th counted tick.
- Retrigger of a held key reuses the same slot and keeps its keys_on bit at 1, with no gap.
- Stolen slot: keys_on stays 1; key and velocity are replaced.
- frame_tick in IDLE or SCAN is ignored.

Test Plan:
- Reset, then note-on key 60 vel 100 → after VOICES+2 cycles: cur_key_adr=0, cur_key_val=60, cur_vel_on=100, note_on=1, keys_on=0x01; ev_ready low until 2 frame_ticks have been seen.
- Note-on 60, 62, 64, then note-off 62 → keys_on=0x07 then 0x05; last commit cur_key_adr=1, note_on=0, cur_vel_on=vel of 64.
- Note-on key 60 twice (vel 100, then 50) → second commit cur_key_adr=0, cur_vel_on=50, keys_on=0x01.
- 8 note-ons with keys 40..47, then key 50, then key 51 → key 50 steals slot 0 and key 51 steals slot 1; keys_on stays 0xFF.
- Note-off for an unheld key 70 → no output change; ev_ready high again VOICES+2 cycles after the handshake. Note-on with vel 0 for a held key behaves as note-off.
- all_notes_off asserted together with ev_valid in IDLE → ev_ready=0, keys_on=0x00, event not accepted. Assert n_reset low during SCAN → all outputs 0 immediately, state IDLE.

Source files
------------

// File: rtl/voice_alloc_sched.sv
// Polyphonic voice allocator: maps note-on/off events onto voice slots and
// holds each committed result for HOLD_FRAMES voice frames.
`timescale 1ns/1ps
module voice_alloc_sched #(
  parameter int VOICES      = 8,
  parameter int V_WIDTH     = 3,
  parameter int HOLD_FRAMES = 2
) (
  input  logic               OSC_CLK,
  input  logic               n_reset,
  input  logic               frame_tick,
  input  logic               ev_valid,
  output logic               ev_ready,
  input  logic               ev_note_on,
  input  logic [7:0]         ev_key,
  input  logic [7:0]         ev_vel,
  input  logic               all_notes_off,
  output logic               note_on,
  output logic [V_WIDTH-1:0] cur_key_adr,
  output logic [7:0]         cur_key_val,
  output logic [7:0]         cur_vel_on,
  output logic [VOICES-1:0]  keys_on,
  output logic               busy,
  output logic [1:0]         dbg_state
);

  // Handshake: an event (or all_notes_off) is taken only in IDLE, on a
  // rising OSC_CLK edge where ev_valid && ev_ready; ev_valid must hold until then.
  typedef enum logic [1:0] {S_IDLE, S_SCAN, S_COMMIT, S_HOLD} state_t;

  localparam int CW = (HOLD_FRAMES > 1) ? $clog2(HOLD_FRAMES) : 1;
  localparam logic [CW-1:0]      HOLD_LAST = CW'(HOLD_FRAMES - 1);
  localparam logic [V_WIDTH-1:0] V_LAST    = V_WIDTH'(VOICES - 1);

  state_t               r_state;
  state_t               w_next;
  logic [7:0]           r_key;
  logic [7:0]           r_vel;
  logic                 r_is_on;
  logic [V_WIDTH-1:0]   r_idx;
  logic                 r_match_found;
  logic [V_WIDTH-1:0]   r_match_idx;
  logic                 r_free_found;
  logic [V_WIDTH-1:0]   r_free_idx;
  logic [V_WIDTH-1:0]   r_steal_ptr;
  logic [7:0]           r_key_tab [VOICES];
  logic [VOICES-1:0]    r_keys_on;
  logic                 r_note_on;
  logic [V_WIDTH-1:0]   r_cur_adr;
  logic [7:0]           r_cur_val;
  logic [7:0]           r_cur_vel;
  logic [CW-1:0]        r_frame_cnt;

  logic                 w_hit;
  logic                 w_steal;
  logic [V_WIDTH-1:0]   w_slot;

  assign ev_ready    = (r_state == S_IDLE) && !all_notes_off;
  assign busy        = (r_state != S_IDLE);
  assign dbg_state   = r_state;
  assign note_on     = r_note_on;
  assign cur_key_adr = r_cur_adr;
  assign cur_key_val = r_cur_val;
  assign cur_vel_on  = r_cur_vel;
  assign keys_on     = r_keys_on;

  assign w_hit = r_keys_on[r_idx] && (r_key_tab[r_idx] == r_key);

  // Slot priority for a note-on: held key, then first free, then steal.
  always_comb begin
    w_steal = 1'b0;
    w_slot  = r_steal_ptr;
    if (r_match_found) begin
      w_slot = r_match_idx;
    end else if (r_free_found) begin
      w_slot = r_free_idx;
    end else begin
      w_steal = 1'b1;
    end
  end

  always_ff @(posedge OSC_CLK or negedge n_reset) begin
    if (!n_reset) r_state <= S_IDLE;
    else          r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (all_notes_off)  w_next = S_HOLD;
        else if (ev_valid)  w_next = S_SCAN;
      end
      S_SCAN: begin
        if (r_idx == V_LAST) w_next = S_COMMIT;
      end
      S_COMMIT: begin
        // A note-off for an unheld key changes nothing, so skip the hold.
        if (r_is_on || r_match_found) w_next = S_HOLD;
        else                          w_next = S_IDLE;
      end
      S_HOLD: begin
        if (frame_tick && (r_frame_cnt == HOLD_LAST)) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge OSC_CLK or negedge n_reset) begin
    if (!n_reset) begin
      r_key         <= '0;
      r_vel         <= '0;
      r_is_on       <= 1'b0;
      r_idx         <= '0;
      r_match_found <= 1'b0;
      r_match_idx   <= '0;
      r_free_found  <= 1'b0;
      r_free_idx    <= '0;
      r_steal_ptr   <= '0;
      r_keys_on     <= '0;
      r_note_on     <= 1'b0;
      r_cur_adr     <= '0;
      r_cur_val     <= '0;
      r_cur_vel     <= '0;
      r_frame_cnt   <= '0;
      for (int i = 0; i < VOICES; i++) r_key_tab[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_frame_cnt <= '0;
          if (all_notes_off) begin
            r_keys_on <= '0;
            r_note_on <= 1'b0;
          end else if (ev_valid) begin
            r_key         <= ev_key;
            r_vel         <= ev_vel;
            r_is_on       <= ev_note_on && (ev_vel != 8'd0);
            r_match_found <= 1'b0;
            r_free_found  <= 1'b0;
            r_idx         <= '0;
          end
        end
        S_SCAN: begin
          if (!r_match_found && w_hit) begin
            r_match_found <= 1'b1;
            r_match_idx   <= r_idx;
          end
          if (!r_free_found && !r_keys_on[r_idx]) begin
            r_free_found <= 1'b1;
            r_free_idx   <= r_idx;
          end
          r_idx <= r_idx + 1'b1;
        end
        S_COMMIT: begin
          if (r_is_on) begin
            r_key_tab[w_slot] <= r_key;
            r_keys_on[w_slot] <= 1'b1;
            r_cur_adr         <= w_slot;
            r_cur_val         <= r_key;
            r_cur_vel         <= r_vel;
            r_note_on         <= 1'b1;
            if (w_steal) r_steal_ptr <= (r_steal_ptr == V_LAST) ? '0 : r_steal_ptr + 1'b1;
          end else if (r_match_found) begin
            r_keys_on[r_match_idx] <= 1'b0;
            r_cur_adr              <= r_match_idx;
            r_cur_val              <= r_key;
            r_note_on              <= 1'b0;
          end
        end
        S_HOLD: begin
          if (frame_tick) r_frame_cnt <= (r_frame_cnt == HOLD_LAST) ? '0 : r_frame_cnt + 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_voice_alloc_sched.sv
// Directed bench for voice_alloc_sched: a behavioural allocator model pushes
// expected commits to a queue that is popped when the DUT commits.
`timescale 1ns/1ps
module tb_voice_alloc_sched;
  localparam int VOICES      = 8;
  localparam int V_WIDTH     = 3;
  localparam int HOLD_FRAMES = 2;

  logic               clk = 1'b0;
  logic               n_reset = 1'b0;
  logic               frame_tick = 1'b0;
  logic               ev_valid = 1'b0;
  logic               ev_note_on = 1'b0;
  logic [7:0]         ev_key = '0;
  logic [7:0]         ev_vel = '0;
  logic               all_notes_off = 1'b0;
  logic               ev_ready;
  logic               note_on;
  logic [V_WIDTH-1:0] cur_key_adr;
  logic [7:0]         cur_key_val;
  logic [7:0]         cur_vel_on;
  logic [VOICES-1:0]  keys_on;
  logic               busy;
  logic [1:0]         dbg_state;

  voice_alloc_sched #(.VOICES(VOICES), .V_WIDTH(V_WIDTH), .HOLD_FRAMES(HOLD_FRAMES)) dut (
    .OSC_CLK(clk), .n_reset(n_reset), .frame_tick(frame_tick), .ev_valid(ev_valid),
    .ev_ready(ev_ready), .ev_note_on(ev_note_on), .ev_key(ev_key), .ev_vel(ev_vel),
    .all_notes_off(all_notes_off), .note_on(note_on), .cur_key_adr(cur_key_adr),
    .cur_key_val(cur_key_val), .cur_vel_on(cur_vel_on), .keys_on(keys_on),
    .busy(busy), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_err    = 0;

  // {hold, adr, key, vel, note_on, keys_on}
  logic [28:0] exp_q[$];

  logic [7:0]         m_tab [VOICES];
  logic [VOICES-1:0]  m_keys;
  logic [V_WIDTH-1:0] m_ptr;
  logic [V_WIDTH-1:0] m_adr;
  logic [7:0]         m_val;
  logic [7:0]         m_vel;
  logic               m_non;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < VOICES; i++) m_tab[i] = '0;
    m_keys = '0; m_ptr = '0; m_adr = '0; m_val = '0; m_vel = '0; m_non = 1'b0;
  endtask

  task automatic model_event(input logic on, input logic [7:0] key, input logic [7:0] vel,
                             output logic hold);
    int match = -1;
    int free  = -1;
    int slot;
    for (int i = 0; i < VOICES; i++) begin
      if (match < 0 && m_keys[i] && m_tab[i] == key) match = i;
      if (free < 0 && !m_keys[i]) free = i;
    end
    hold = 1'b1;
    if (on && vel != 8'd0) begin
      if (match >= 0)     slot = match;
      else if (free >= 0) slot = free;
      else begin
        slot  = int'(m_ptr);
        m_ptr = V_WIDTH'((int'(m_ptr) + 1) % VOICES);
      end
      m_tab[slot] = key; m_keys[slot] = 1'b1;
      m_adr = V_WIDTH'(slot); m_val = key; m_vel = vel; m_non = 1'b1;
    end else if (match >= 0) begin
      m_keys[match] = 1'b0;
      m_adr = V_WIDTH'(match); m_val = key; m_non = 1'b0;
    end else begin
      hold = 1'b0;
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_adr"},  32'(cur_key_adr), 0);
    check({tag, "_val"},  32'(cur_key_val), 0);
    check({tag, "_vel"},  32'(cur_vel_on), 0);
    check({tag, "_non"},  32'(note_on), 0);
    check({tag, "_keys"}, 32'(keys_on), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  task automatic wait_ready();
    int n = 0;
    while (!ev_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("ready_wait", 32'(ev_ready), 1);
  endtask

  // ev_ready must stay low until the HOLD_FRAMES-th tick seen in HOLD.
  task automatic hold_ticks(input string tag);
    @(posedge clk); @(negedge clk);
    check({tag, "_idle_no_tick"}, 32'(ev_ready), 0);
    for (int k = 1; k <= HOLD_FRAMES; k++) begin
      frame_tick = 1'b1;
      @(posedge clk); @(negedge clk);
      frame_tick = 1'b0;
      check({tag, "_ready_after_tick"}, 32'(ev_ready), 32'(k == HOLD_FRAMES));
    end
  endtask

  // driver: one event; optional frame_tick pulses during SCAN and COMMIT
  task automatic do_event(input string tag, input logic on, input logic [7:0] key,
                          input logic [7:0] vel, input bit tick_noise);
    logic [VOICES-1:0] prev_keys;
    logic              hold;
    logic [28:0]       e;
    wait_ready();
    prev_keys = m_keys;
    model_event(on, key, vel, hold);
    exp_q.push_back({hold, m_adr, m_val, m_vel, m_non, m_keys});
    ev_valid = 1'b1; ev_note_on = on; ev_key = key; ev_vel = vel;
    @(posedge clk); @(negedge clk);
    ev_valid = 1'b0;
    for (int i = 1; i <= VOICES; i++) begin
      frame_tick = tick_noise && (i == 3);
      @(posedge clk); @(negedge clk);
    end
    check({tag, "_pre_keys"}, 32'(keys_on), 32'(prev_keys));
    check({tag, "_pre_busy"}, 32'(busy), 1);
    frame_tick = tick_noise;
    @(posedge clk); @(negedge clk);
    frame_tick = 1'b0;
    e = exp_q.pop_front();
    check({tag, "_adr"},  32'(cur_key_adr), 32'(e[27:25]));
    check({tag, "_val"},  32'(cur_key_val), 32'(e[24:17]));
    check({tag, "_vel"},  32'(cur_vel_on),  32'(e[16:9]));
    check({tag, "_non"},  32'(note_on),     32'(e[8]));
    check({tag, "_keys"}, 32'(keys_on),     32'(e[7:0]));
    if (e[28]) begin
      check({tag, "_ready_held"}, 32'(ev_ready), 0);
      hold_ticks(tag);
    end else begin
      check({tag, "_ready_nohold"}, 32'(ev_ready), 1);
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  initial begin
    model_reset();
    repeat (2) @(negedge clk);
    check_zero("reset");
    check("reset_ready", 32'(ev_ready), 1);
    n_reset = 1'b1;
    @(negedge clk);

    do_event("on60",  1'b1, 8'd60, 8'd100, 1'b1);
    do_event("on62",  1'b1, 8'd62, 8'd80,  1'b0);
    do_event("on64",  1'b1, 8'd64, 8'd90,  1'b0);
    do_event("off62", 1'b0, 8'd62, 8'd0,   1'b0);
    do_event("retrig60", 1'b1, 8'd60, 8'd50, 1'b0);

    // all_notes_off wins over a simultaneous event
    wait_ready();
    all_notes_off = 1'b1; ev_valid = 1'b1; ev_note_on = 1'b1; ev_key = 8'd33; ev_vel = 8'd44;
    #1;
    check("anoff_ready", 32'(ev_ready), 0);
    @(posedge clk); @(negedge clk);
    all_notes_off = 1'b0; ev_valid = 1'b0;
    m_keys = '0; m_non = 1'b0;
    check("anoff_keys", 32'(keys_on), 0);
    check("anoff_non",  32'(note_on), 0);
    check("anoff_busy", 32'(busy), 1);
    check("anoff_adr",  32'(cur_key_adr), 32'(m_adr));
    check("anoff_vel",  32'(cur_vel_on), 32'(m_vel));
    hold_ticks("anoff");

    for (int k = 0; k < VOICES; k++) begin
      do_event("fill", 1'b1, 8'(40 + k), 8'(10 + k), 1'b0);
    end
    do_event("steal50", 1'b1, 8'd50, 8'd70, 1'b0);
    do_event("steal51", 1'b1, 8'd51, 8'd71, 1'b0);
    do_event("off_unheld70", 1'b0, 8'd70, 8'd5, 1'b0);
    do_event("vel0_45", 1'b1, 8'd45, 8'd0, 1'b0);
    do_event("off50", 1'b0, 8'd50, 8'd0, 1'b0);
    do_event("free52", 1'b1, 8'd52, 8'd33, 1'b1);

    // reset in the middle of a scan
    wait_ready();
    ev_valid = 1'b1; ev_note_on = 1'b1; ev_key = 8'd99; ev_vel = 8'd99;
    @(posedge clk); @(negedge clk);
    ev_valid = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("scan_state", 32'(dbg_state), 1);
    n_reset = 1'b0;
    #1;
    check_zero("midscan_rst");
    check("midscan_state", 32'(dbg_state), 0);
    model_reset();
    @(negedge clk);
    n_reset = 1'b1;
    @(negedge clk);
    do_event("post_rst60", 1'b1, 8'd60, 8'd7, 1'b0);

    check("exp_q_empty", 32'(exp_q.size()), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
